// File: rtl/id_queue_pkg.sv
// Shared RV32I decode constants, record types and immediate extraction for the id_queue slice.
// Imported by the decoder core, the queue top and the handshake interface.
package id_queue_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_JALR    = 3'b000;
   localparam logic [2:0] F3_BR_RSV0 = 3'b010;
   localparam logic [2:0] F3_BR_RSV1 = 3'b011;
   localparam logic [2:0] F3_LD_RSV0 = 3'b011;
   localparam logic [2:0] F3_LD_RSV1 = 3'b110;
   localparam logic [2:0] F3_LD_RSV2 = 3'b111;
   localparam logic [2:0] F3_ST_MAX  = 3'b010;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      TYPE_R   = 3'd0,
      TYPE_I   = 3'd1,
      TYPE_S   = 3'd2,
      TYPE_B   = 3'd3,
      TYPE_U   = 3'd4,
      TYPE_J   = 3'd5,
      TYPE_ILL = 3'd7
   } inst_type_e;

   // Everything except pc and imm, whose width follows XLEN.
   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      inst_type_e inst_type;
      logic       rd_we;
      logic       rs1_re;
      logic       rs2_re;
      logic       err;
   } dec_rec_t;

   function automatic logic [31:0] imm_of(input logic [31:0] inst, input inst_type_e fmt);
      logic [31:0] imm;
      imm = '0;
      case (fmt)
         TYPE_I:  imm = {{20{inst[31]}}, inst[31:20]};
         TYPE_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         TYPE_B:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         TYPE_U:  imm = {inst[31:12], 12'h000};
         TYPE_J:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/id_queue_if.sv
// Fetch-side and execute-side handshake bundle of the id_queue decode stage.
// slave = the queue itself, master = the surrounding pipeline (fetch + execute).
interface id_queue_if #(
   parameter int unsigned XLEN = 32
);
   import id_queue_pkg::*;

   logic            inst_valid_i;
   logic            inst_ready_o;
   logic [31:0]     inst_data_i;
   logic [XLEN-1:0] inst_addr_i;
   logic            flush_i;

   logic            dec_valid_o;
   logic            dec_ready_i;
   logic [XLEN-1:0] pc_o;
   logic [6:0]      opcode_o;
   logic [2:0]      funct3_o;
   logic [6:0]      funct7_o;
   logic [4:0]      rd_o;
   logic [4:0]      rs1_o;
   logic [4:0]      rs2_o;
   logic [XLEN-1:0] imm_o;
   inst_type_e      inst_type_o;
   logic            rd_we_o;
   logic            rs1_re_o;
   logic            rs2_re_o;
   logic            id_err_o;

   modport slave (
      input  inst_valid_i, inst_data_i, inst_addr_i, flush_i, dec_ready_i,
      output inst_ready_o, dec_valid_o, pc_o, opcode_o, funct3_o, funct7_o,
             rd_o, rs1_o, rs2_o, imm_o, inst_type_o, rd_we_o, rs1_re_o,
             rs2_re_o, id_err_o
   );

   modport master (
      output inst_valid_i, inst_data_i, inst_addr_i, flush_i, dec_ready_i,
      input  inst_ready_o, dec_valid_o, pc_o, opcode_o, funct3_o, funct7_o,
             rd_o, rs1_o, rs2_o, imm_o, inst_type_o, rd_we_o, rs1_re_o,
             rs2_re_o, id_err_o
   );

endinterface

// File: rtl/id_queue_dec_core.sv
// Purely combinational RV32I instruction-to-record decoder.
// Illegal encodings yield an all-zero record typed ILL with err set.
module id_dec_core
   import id_queue_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter bit          M_EXT = 1'b0
) (
   input  logic [31:0]     inst,
   output dec_rec_t        rec,
   output logic [XLEN-1:0] imm
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       legal;
   logic       shift_imm;
   logic       op_f7_ok;
   inst_type_e fmt;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];

   assign shift_imm = (opc == OPC_OP_IMM) && ((f3 == F3_SLL) || (f3 == F3_SRL_SRA));

   // The alternate funct7 is only meaningful for SUB and SRA.
   always_comb begin
      op_f7_ok = DISABLE;
      if (f7 == F7_BASE)
         op_f7_ok = ENABLE;
      else if (f7 == F7_ALT)
         op_f7_ok = (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
      else if (f7 == F7_MULDIV)
         op_f7_ok = M_EXT;
   end

   always_comb begin
      fmt   = TYPE_ILL;
      legal = DISABLE;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            fmt   = TYPE_U;
            legal = ENABLE;
         end
         OPC_JAL: begin
            fmt   = TYPE_J;
            legal = ENABLE;
         end
         OPC_JALR: begin
            fmt   = TYPE_I;
            legal = (f3 == F3_JALR);
         end
         OPC_BRANCH: begin
            fmt   = TYPE_B;
            legal = (f3 != F3_BR_RSV0) && (f3 != F3_BR_RSV1);
         end
         OPC_LOAD: begin
            fmt   = TYPE_I;
            legal = (f3 != F3_LD_RSV0) && (f3 != F3_LD_RSV1) && (f3 != F3_LD_RSV2);
         end
         OPC_STORE: begin
            fmt   = TYPE_S;
            legal = (f3 <= F3_ST_MAX);
         end
         OPC_OP_IMM: begin
            fmt = TYPE_I;
            if (f3 == F3_SLL)
               legal = (f7 == F7_BASE);
            else if (f3 == F3_SRL_SRA)
               legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            else
               legal = ENABLE;
         end
         OPC_OP: begin
            fmt   = TYPE_R;
            legal = op_f7_ok;
         end
         OPC_FENCE, OPC_SYSTEM: begin
            fmt   = TYPE_I;
            legal = ENABLE;
         end
         default: begin
            fmt   = TYPE_ILL;
            legal = DISABLE;
         end
      endcase
      if (inst[1:0] != 2'b11)
         legal = DISABLE;
   end

   always_comb begin
      rec = '0;
      imm = '0;
      if (legal) begin
         rec.opcode    = opc;
         rec.inst_type = fmt;
         rec.rd_we     = (fmt != TYPE_S) && (fmt != TYPE_B);
         rec.rs1_re    = (fmt != TYPE_U) && (fmt != TYPE_J);
         rec.rs2_re    = (fmt == TYPE_R) || (fmt == TYPE_S) || (fmt == TYPE_B);
         rec.rd        = rec.rd_we  ? inst[11:7]  : 5'd0;
         rec.rs1       = rec.rs1_re ? inst[19:15] : 5'd0;
         rec.rs2       = rec.rs2_re ? inst[24:20] : 5'd0;
         rec.funct3    = ((fmt == TYPE_U) || (fmt == TYPE_J)) ? 3'd0 : f3;
         rec.funct7    = ((fmt == TYPE_R) || shift_imm) ? f7 : 7'd0;
         imm           = XLEN'($signed(imm_of(inst, fmt)));
      end else begin
         rec.inst_type = TYPE_ILL;
         rec.err       = ENABLE;
      end
   end

endmodule

// File: rtl/id_queue.sv
// Registered RV32I decode stage: decodes on entry and buffers DEPTH records in a FIFO
// with valid/ready on both sides; flush empties it and drops a same-cycle push.
module id_queue
   import id_queue_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter bit          M_EXT = 1'b0
) (
   input logic       clk,
   input logic       rst,
   id_queue_if.slave bus
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   dec_rec_t        rec_mem [DEPTH];
   logic [XLEN-1:0] pc_mem  [DEPTH];
   logic [XLEN-1:0] imm_mem [DEPTH];

   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;

   dec_rec_t        new_rec;
   logic [XLEN-1:0] new_imm;
   dec_rec_t        head_rec;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_imm;
   logic            push;
   logic            pop;

   id_dec_core #(
      .XLEN  (XLEN),
      .M_EXT (M_EXT)
   ) u_dec_core (
      .inst (bus.inst_data_i),
      .rec  (new_rec),
      .imm  (new_imm)
   );

   // Ready depends only on occupancy, so execute-side stalls never reach fetch combinationally.
   assign bus.inst_ready_o = !rst && (count != FULL_CNT);
   assign bus.dec_valid_o  = (count != '0);

   assign push = bus.inst_valid_i && bus.inst_ready_o;
   assign pop  = bus.dec_valid_o && bus.dec_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !bus.flush_i) begin
         rec_mem[wr_ptr] <= new_rec;
         pc_mem[wr_ptr]  <= bus.inst_addr_i;
         imm_mem[wr_ptr] <= new_imm;
      end
   end

   // Storage is not reset; gating on occupancy keeps every output at zero when empty or in reset.
   always_comb begin
      head_rec = '0;
      head_pc  = '0;
      head_imm = '0;
      if (bus.dec_valid_o) begin
         head_rec = rec_mem[rd_ptr];
         head_pc  = pc_mem[rd_ptr];
         head_imm = imm_mem[rd_ptr];
      end
   end

   assign bus.pc_o        = head_pc;
   assign bus.imm_o       = head_imm;
   assign bus.opcode_o    = head_rec.opcode;
   assign bus.funct3_o    = head_rec.funct3;
   assign bus.funct7_o    = head_rec.funct7;
   assign bus.rd_o        = head_rec.rd;
   assign bus.rs1_o       = head_rec.rs1;
   assign bus.rs2_o       = head_rec.rs2;
   assign bus.inst_type_o = head_rec.inst_type;
   assign bus.rd_we_o     = head_rec.rd_we;
   assign bus.rs1_re_o    = head_rec.rs1_re;
   assign bus.rs2_re_o    = head_rec.rs2_re;
   assign bus.id_err_o    = head_rec.err;

endmodule
